// File: rtl/move_tx.sv
// move_tx: serializes one (row, col) move onto the game-core pin bus and waits for the echo.
// Ports: clk, rst, req_* handshake, ack_row/ack_col, pins, busy/done/err/err_code. Macro: MOVE_TX_RETRY_EN.
module move_tx #(
  parameter int ROW_HOLD    = 2,
  parameter int GAP_HOLD    = 1,
  parameter int COL_HOLD    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_row,
  input  logic [2:0] req_col,
  input  logic [2:0] ack_row,
  input  logic [2:0] ack_col,
  output logic [7:0] pins,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int HMAX0 = (ROW_HOLD > GAP_HOLD) ? ROW_HOLD : GAP_HOLD;
  localparam int HMAX  = (HMAX0 > COL_HOLD) ? HMAX0 : COL_HOLD;
  localparam int CW    = $clog2(HMAX) + 1;
  localparam int TW    = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_COL  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [7:0] IDLE_PAT = 8'hFF;

  localparam logic [CW-1:0] ROW_LAST = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_HOLD - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_HOLD - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    row_q;
  logic [2:0]    col_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic          match;

  // k=1 selects nothing on the bus; k=2..7 walks a single one upward.
  function automatic logic [7:0] enc(input logic [2:0] k);
    if (k == 3'd1) enc = 8'h00;
    else           enc = 8'h01 << (k - 3'd2);
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign match     = (ack_row == row_q) && (ack_col == col_q);

`ifdef MOVE_TX_RETRY_EN
  logic retried;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pins     <= IDLE_PAT;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      cnt      <= '0;
      tmr      <= '0;
`ifdef MOVE_TX_RETRY_EN
      retried  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef MOVE_TX_RETRY_EN
          retried <= 1'b0;
`endif
          if (req_valid) begin
            if (req_row == 3'd0 || req_row == 3'd7) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else if (req_col == 3'd0) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end else begin
              row_q <= req_row;
              col_q <= req_col;
              pins  <= enc(req_row);
              cnt   <= '0;
              state <= S_ROW;
            end
          end
        end
        S_ROW: begin
          if (cnt == ROW_LAST) begin
            pins  <= IDLE_PAT;
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            pins  <= enc(col_q);
            cnt   <= '0;
            state <= S_COL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COL: begin
          if (cnt == COL_LAST) begin
            pins  <= IDLE_PAT;
            cnt   <= '0;
            tmr   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A match on the expiry cycle wins over the timeout.
          if (match) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (tmr == TMR_LAST) begin
`ifdef MOVE_TX_RETRY_EN
            if (!retried) begin
              retried <= 1'b1;
              pins    <= enc(row_q);
              cnt     <= '0;
              state   <= S_ROW;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b11;
              state    <= S_IDLE;
            end
`else
            err      <= 1'b1;
            err_code <= 2'b11;
            state    <= S_IDLE;
`endif
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          pins  <= IDLE_PAT;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_tx.sv
// tb_move_tx: randomized directed bench for move_tx against a sequence-level model.
// Drives requests/acks, checks pins/busy/done/err/err_code every cycle.
module tb_move_tx;

  localparam int RH = 2;
  localparam int GH = 1;
  localparam int CH = 2;
  localparam int AT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_row;
  logic [2:0] req_col;
  logic [2:0] ack_row;
  logic [2:0] ack_col;
  logic [7:0] pins;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int last_code = 0;

  move_tx #(
    .ROW_HOLD(RH),
    .GAP_HOLD(GH),
    .COL_HOLD(CH),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_row(req_row),
    .req_col(req_col),
    .ack_row(ack_row),
    .ack_col(ack_col),
    .pins(pins),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: 1 -> nothing, k -> bit (k-2).
  function automatic int enc_m(input int k);
    if (k == 1) return 0;
    return 2 ** (k - 2);
  endfunction

  task automatic outs(input string tag, input int p, input int b,
                      input int d, input int e);
    chk({tag, ".pins"}, 32'(pins), p);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".ready"}, 32'(req_ready), 1 - b);
    chk({tag, ".done"}, 32'(done), d);
    chk({tag, ".err"}, 32'(err), e);
  endtask

  task automatic idle_chk(input string tag);
    outs(tag, 8'hFF, 0, 0, 0);
    chk({tag, ".code"}, 32'(err_code), last_code);
  endtask

  task automatic phase(input string tag, input int val, input int n);
    for (int i = 0; i < n; i++) begin
      outs(tag, val, 1, 0, 0);
      req_valid = 1'($urandom);
      req_row   = 3'($urandom);
      req_col   = 3'($urandom);
      step();
    end
  endtask

  // d: WAIT_ACK cycle (first attempt) on which the echo matches; d>=AT never.
  task automatic run_move(input int r, input int c, input int d);
    int attempts;
`ifdef MOVE_TX_RETRY_EN
    attempts = 2;
`else
    attempts = 1;
`endif
    ack_row   = 3'd0;
    ack_col   = 3'd0;
    req_valid = 1'b1;
    req_row   = 3'(r);
    req_col   = 3'(c);
    step();
    if (r < 1 || r > 6 || c < 1) begin
      req_valid = 1'b0;
      last_code = (r < 1 || r > 6) ? 1 : 2;
      outs("reject", 8'hFF, 0, 0, 1);
      chk("reject.code", 32'(err_code), last_code);
      return;
    end
    for (int a = 0; a < attempts; a++) begin
      phase("row", enc_m(r), RH);
      phase("gap", 8'hFF, GH);
      phase("col", enc_m(c), CH);
      req_valid = 1'b0;
      for (int w = 0; w < AT; w++) begin
        outs("wait", 8'hFF, 1, 0, 0);
        if (a == 0 && w == d) begin
          ack_row = 3'(r);
          ack_col = 3'(c);
        end else if (w % 2 == 1) begin
          ack_row = 3'(r);
          ack_col = 3'((c % 7) + 1);
        end else begin
          ack_row = 3'((r % 6) + 1);
          ack_col = 3'(c);
        end
        step();
        if (a == 0 && w == d) begin
          ack_row = 3'd0;
          ack_col = 3'd0;
          outs("done", 8'hFF, 0, 1, 0);
          chk("done.code", 32'(err_code), last_code);
          return;
        end
      end
    end
    ack_row   = 3'd0;
    ack_col   = 3'd0;
    last_code = 3;
    outs("timeout", 8'hFF, 0, 0, 1);
    chk("timeout.code", 32'(err_code), 3);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_row   = 3'd0;
    req_col   = 3'd0;
    ack_row   = 3'd0;
    ack_col   = 3'd0;
    step();
    step();
    rst = 1'b0;
    idle_chk("reset");

    run_move(3, 5, 2);
    run_move(1, 7, 0);
    run_move(0, 4, 0);
    run_move(2, 0, 0);
    run_move(7, 0, 0);
    req_valid = 1'b0;
    step();
    idle_chk("hold_code");
    run_move(4, 2, 100);
    run_move(5, 3, AT - 1);

    // Reset during the column phase.
    req_valid = 1'b1;
    req_row   = 3'd6;
    req_col   = 3'd2;
    step();
    phase("mr_row", enc_m(6), RH);
    phase("mr_gap", 8'hFF, GH);
    outs("mr_col", enc_m(2), 1, 0, 0);
    req_valid = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    last_code = 0;
    idle_chk("mid_reset");
    run_move(6, 1, 5);

    for (int n = 0; n < 30; n++) begin
      int r, c, d, gap;
      r   = $urandom_range(0, 7);
      c   = $urandom_range(0, 7);
      d   = $urandom_range(0, 20);
      gap = $urandom_range(0, 2);
      run_move(r, c, d);
      req_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        idle_chk("gap_idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_tx.md
Name: move_tx

Overview:
- Transmit side of the board-game pin interface: serializes one (row, col) move request onto the 8-bit `pins` bus that the game core samples.
- Drives a row phase, an idle gap, then a column phase, using the one-hot-minus-one code.
- Then watches the core's echoed row/col outputs to confirm the move was placed.
- Sits between the user-input front end (buttons/keypad) and the game core.

Parameters:
- ROW_HOLD, 2, cycles the row code is held on `pins` (≥1)
- GAP_HOLD, 1, cycles of idle pattern between row and col phases (≥1)
- COL_HOLD, 2, cycles the col code is held on `pins` (≥1)
- ACK_TIMEOUT, 16, max cycles in WAIT_ACK before timeout error (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  move request valid
- req_ready  out  1  high only in IDLE; transfer when req_valid & req_ready
- req_row  in  3  requested row, legal 1..6
- req_col  in  3  requested column, legal 1..7
- ack_row  in  3  row echoed by game core after placement
- ack_col  in  3  col echoed by game core after placement
- pins  out  8  encoded pin bus to game core
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: move acknowledged
- err  out  1  one-cycle pulse: request rejected or ack timeout
- err_code  out  2  valid with err: 01 illegal row, 10 illegal col, 11 timeout; holds last value otherwise

Behaviour:
- Encoding enc(k): k=1 → 8'h00; k=2..7 → 8'h01 << (k-2). Idle pattern IDLE_PAT = 8'hFF (decodes to "no selection").
- Reset (takes priority over everything; from any state, mid-transfer included):
  - state=IDLE, pins=8'hFF, req_ready=1, busy=0, done=0, err=0, err_code=00, internal counters=0.
- States: IDLE, ROW, GAP, COL, WAIT_ACK.
- IDLE, on accept (registered; state changes on the next edge):
  - req_row ∉ 1..6 → stay IDLE, err=1 and err_code=01 for 1 cycle. Row is checked first, so a request with both fields illegal reports 01.
  - else req_col ∉ 1..7 → stay IDLE, err=1 and err_code=10 for 1 cycle.
  - else latch row/col → ROW, pins=enc(row), counter=0.
- ROW: hold pins for exactly ROW_HOLD cycles → GAP, pins=8'hFF.
- GAP: GAP_HOLD cycles → COL, pins=enc(col).
- COL: COL_HOLD cycles → WAIT_ACK, pins=8'hFF, timer=0.
- WAIT_ACK:
  - Each cycle, if ack_row==latched row and ack_col==latched col → IDLE with done=1 for 1 cycle.
  - Else timer++. When timer reaches ACK_TIMEOUT without a match → IDLE with err=1, err_code=11.
  - A match on the same cycle the timer expires counts as done, not err.
- done and err are never high together.
- req_ready=0 outside IDLE; req_valid is ignored while busy; request inputs are sampled only at acceptance.
- A new request may be accepted on the first IDLE cycle after done/err; back-to-back moves are permitted.
- pins changes only at phase boundaries; glitch-free, registered output.
- Counter widths sized by $clog2 of their parameter + 1; no wrap is possible before the terminal compare.

Optional Feature:
- Macro: MOVE_TX_RETRY_EN.
- Defined: on the first ACK_TIMEOUT expiry, no err is raised. The block re-enters ROW with the same latched move and replays the full row/gap/col sequence once. A second timeout raises err=1, err_code=11. A retry flag resets in IDLE and on rst.
- Undefined: the first timeout raises err immediately, with no retry logic present.

Test Plan:
- Reset then idle: assert rst 2 cycles → pins=8'hFF, req_ready=1, busy=0, done=0, err=0, err_code=00.
- Legal move row=3, col=5, ack echoes 3/5 two cycles after col phase ends, defaults:
  - pins=8'h02 for 2 cycles, 8'hFF for 1, 8'h08 for 2, then 8'hFF.
  - done pulses once; busy drops the same cycle.
- Encoding edges: row=1, col=7 → row phase pins=8'h00, col phase pins=8'h20.
- Illegal requests:
  - row=0, col=4 → err=1, err_code=01 for one cycle; pins stay 8'hFF; req_ready stays 1.
  - row=2, col=0 → err_code=10.
- Timeout: legal move with ack held at 0/0 → exactly ACK_TIMEOUT=16 cycles after WAIT_ACK entry, err=1, err_code=11. With MOVE_TX_RETRY_EN defined, the sequence replays once first, then err fires.
- Reset mid-move: assert rst during COL phase → next cycle pins=8'hFF, state IDLE, no done/err pulse; a following legal request completes normally.
